// File: rtl/darkseg_bcd.sv
// darkseg_bcd: sequential double-dabble binary-to-BCD converter for the
// 8-digit 7-segment display. One conversion takes 34 cycles (accept edge,
// 32 shift edges, one load edge). Results saturate to 99999999 with OVF set.
// Optional macro DARKSEG_BCD_SIGNED_EN: treat BIN as two's complement,
// convert |BIN| and report the sign on NEG. Without it NEG is tied to 0.
module darkseg_bcd (
   input  logic        CLK,
   input  logic        RES,
   input  logic        START,
   input  logic [31:0] BIN,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] BCD,
   output logic        OVF,
   output logic        NEG
);

   typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

   state_e      state_q;
   logic [31:0] sr_q;     // binary bits still to be shifted into the accumulator
   logic [39:0] acc_q;    // 10 BCD digits: a 32-bit value never exceeds 4294967295
   logic [5:0]  cnt_q;
   logic [39:0] acc_adj;  // accumulator after the add-3 correction
   logic [31:0] bin_mag;  // value latched on the accepting edge

`ifdef DARKSEG_BCD_SIGNED_EN
   logic sign_q;

   // Magnitude of the two's-complement input; 0x80000000 maps to 2147483648.
   always_comb begin
      bin_mag = BIN[31] ? (~BIN + 32'd1) : BIN;
   end
`else
   // Unsigned input is converted as-is.
   always_comb begin
      bin_mag = BIN;
   end

   assign NEG = 1'b0;
`endif

   // Double-dabble correction: any digit >= 5 gets +3 before the shift.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < 10; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Control FSM, datapath and registered outputs; display regs move only on LOAD.
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state_q <= StIdle;
         sr_q    <= 32'd0;
         acc_q   <= 40'd0;
         cnt_q   <= 6'd0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         BCD     <= 32'd0;
         OVF     <= 1'b0;
`ifdef DARKSEG_BCD_SIGNED_EN
         sign_q  <= 1'b0;
         NEG     <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  sr_q    <= bin_mag;
                  acc_q   <= 40'd0;
                  cnt_q   <= 6'd0;
                  BUSY    <= 1'b1;
                  state_q <= StShift;
`ifdef DARKSEG_BCD_SIGNED_EN
                  sign_q  <= BIN[31];
`endif
               end
            end
            StShift: begin
               acc_q <= {acc_adj[38:0], sr_q[31]};
               sr_q  <= {sr_q[30:0], 1'b0};
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               if (acc_q[39:32] != 8'd0) begin
                  OVF <= 1'b1;
                  BCD <= 32'h9999_9999;
               end else begin
                  OVF <= 1'b0;
                  BCD <= acc_q[31:0];
               end
`ifdef DARKSEG_BCD_SIGNED_EN
               NEG     <= sign_q;
`endif
               DONE    <= 1'b1;
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/darkseg_bcd.md
DARKSEG_BCD -- requirements
Module: darkseg_bcd

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 CLK  input  1  system clock (100 MHz); all state changes on its rising edge.
REQ-003 RES  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  conversion request, sampled on CLK edges.
REQ-005 BIN  input  32  unsigned binary value to convert, sampled on the accepting edge only.
REQ-006 BUSY  output  1  high while a conversion is in progress.
REQ-007 DONE  output  1  one-cycle pulse marking a BCD/OVF/NEG update.
REQ-008 BCD  output  32  8 packed BCD digits, digit 0 in [3:0]; drives the 7-segment controller DATA input directly.
REQ-009 OVF  output  1  last converted magnitude exceeded 99,999,999.
REQ-010 NEG  output  1  last converted value was negative (only meaningful with the macro; see Configuration).

Function
REQ-011 The block SHALL implement a sequential double-dabble converter with states IDLE, SHIFT and LOAD.
REQ-012 In IDLE with START=1, the edge SHALL latch BIN into a 32-bit shift register, clear a 40-bit (10-digit) BCD accumulator and the iteration counter, set BUSY=1, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL first add 3 to every accumulator digit >=5, then shift {accumulator, shift register} left by 1 and increment the counter.
REQ-014 After exactly 32 SHIFT edges, the state SHALL become LOAD.
REQ-015 On the LOAD edge, the block SHALL: set OVF=1 if the upper two digits are nonzero, else 0; set BCD to the lower 8 digits, or to 0x99999999 when OVF=1; set DONE=1, BUSY=0 and state IDLE.
REQ-016 Latency: the edge accepting START plus 33 further edges; DONE is high for exactly the one cycle after the LOAD edge.
REQ-017 BCD, OVF and NEG SHALL change only on the LOAD edge, so the display is stable throughout a conversion.
REQ-018 START SHALL be ignored while BUSY=1, with no queuing.
REQ-019 START in the cycle where DONE=1 SHALL be accepted, because the state is IDLE then; back-to-back conversions run every 34 cycles.
REQ-020 Changes on BIN after the accepting edge SHALL have no effect on the conversion in progress.
REQ-021 DONE SHALL return to 0 on every edge other than the LOAD edge.

Reset
REQ-022 While RES=1, the block SHALL asynchronously force: state IDLE, BUSY=0, DONE=0, BCD=0x00000000, OVF=0, NEG=0, counter and accumulator 0.
REQ-023 Reset asserted mid-conversion SHALL abort it with no DONE pulse; the first START after RES falls SHALL begin a fresh conversion.

Configuration
REQ-024 Macro DARKSEG_BCD_SIGNED_EN selects signed handling of BIN.
- Defined: BIN is two's complement. On the accepting edge, the magnitude |BIN| is latched and a sign flag is captured; NEG is loaded from that flag on the LOAD edge. |0x80000000| = 2147483648 converts as OVF=1.
- Undefined: BIN is unsigned and NEG is constant 0.
- Latency and handshake are identical in both builds.

Verification
REQ-025 Latency: BIN=0x00BC614E (12345678), START pulse at edge 0. Required: BUSY=1 on edges 1-33; DONE pulses after edge 33; BCD=0x12345678; OVF=0.
REQ-026 Boundary: BIN=0x05F5E0FF (99999999) gives BCD=0x99999999, OVF=0. BIN=0x05F5E100 (100000000) gives BCD=0x99999999, OVF=1. BIN=0 gives BCD=0x00000000.
REQ-027 Handshake: START held high continuously with BIN changing every cycle. Required: a DONE pulse every 34 cycles, each result equal to the BIN sampled at its own accepting edge.
REQ-028 Reset mid-operation: assert RES at edge 10 of a conversion of 0x12345678. Required: outputs go to reset values immediately, no DONE pulse; a subsequent conversion of 42 gives BCD=0x00000042.
REQ-029 Signed build: BIN=0xFFFFFFFF gives BCD=0x00000001, NEG=1, OVF=0. Unsigned build: same stimulus gives BCD=0x99999999, OVF=1, NEG=0.
REQ-030 Ignored request: a second START pulse while BUSY=1 with a different BIN. Required: exactly one DONE pulse, result from the first BIN only.
